// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared types and command-word field layout for the i2c command sequencer.
package i2c_cmd_sequencer_pkg;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned CHIP_W = 7;

  typedef enum logic [1:0] {
    OP_END   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_DELAY = 2'd3
  } op_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_ROM,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_DELAY,
    ST_FINISH,
    ST_ERROR
  } state_t;

  // Command word is {op, chip, reg, data}, data in the low bits.
  function automatic int unsigned cmd_width(input int unsigned addr_bytes,
                                            input int unsigned data_bytes);
    return OP_W + CHIP_W + 8 * addr_bytes + 8 * data_bytes;
  endfunction

  function automatic int unsigned reg_lsb(input int unsigned data_bytes);
    return 8 * data_bytes;
  endfunction

  function automatic int unsigned chip_lsb(input int unsigned addr_bytes,
                                           input int unsigned data_bytes);
    return 8 * (addr_bytes + data_bytes);
  endfunction

  function automatic int unsigned op_lsb(input int unsigned addr_bytes,
                                         input int unsigned data_bytes);
    return 8 * (addr_bytes + data_bytes) + CHIP_W;
  endfunction

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_timer.sv
// Loadable down-counter shared by DELAY entries and the transfer watchdog.
module i2c_cmd_sequencer_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command-table walker: fetches entries from a synchronous ROM and runs one
// i2c_master transfer, local delay or termination per entry.
module i2c_cmd_sequencer
  import i2c_cmd_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_BYTES  = 1,
  parameter int unsigned DATA_BYTES  = 2,
  parameter int unsigned CMD_AW      = 8,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned TO_WIDTH    = 20,
  localparam int unsigned AW    = 8 * ADDR_BYTES,
  localparam int unsigned DW    = 8 * DATA_BYTES,
  localparam int unsigned SW    = ADDR_BYTES + DATA_BYTES + 1,
  localparam int unsigned CMD_W = cmd_width(ADDR_BYTES, DATA_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cmd_rd,
  output logic [CMD_AW-1:0] cmd_addr,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic [6:0]        m_chip_addr,
  output logic [AW-1:0]     m_reg_addr,
  output logic [DW-1:0]     m_data,
  output logic              m_write_en,
  output logic              m_read_en,
  output logic              m_write_mode,
  input  logic [DW-1:0]     m_data_out,
  input  logic [SW-1:0]     m_status,
  input  logic              m_done,
  input  logic              m_busy,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_error,
  output logic [CMD_AW-1:0] err_index
);

  localparam int unsigned REG_LSB  = reg_lsb(DATA_BYTES);
  localparam int unsigned CHIP_LSB = chip_lsb(ADDR_BYTES, DATA_BYTES);
  localparam int unsigned OP_LSB   = op_lsb(ADDR_BYTES, DATA_BYTES);
  localparam int unsigned TMR_W    = max_w(TO_WIDTH, DW);
  localparam int unsigned RTY_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TMR_W-1:0] WD_LOAD = TMR_W'({TO_WIDTH{1'b1}});

  state_t             state, state_nxt;
  op_t                op_q, op_nxt;
  logic               nack_q, nack_nxt;
  logic [RTY_W-1:0]   retry_cnt, retry_nxt;
  logic [CMD_AW-1:0]  cmd_addr_nxt, err_index_nxt;
  logic [6:0]         chip_nxt;
  logic [AW-1:0]      reg_nxt;
  logic [DW-1:0]      data_nxt, rd_data_nxt;
  logic               cmd_rd_nxt, write_en_nxt, read_en_nxt;
  logic               rd_valid_nxt, seq_busy_nxt, seq_done_nxt, seq_error_nxt;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;
  logic               last_entry, advance, wd_expired, can_retry;

  assign m_write_mode = 1'b0;
  assign last_entry   = (cmd_addr == {CMD_AW{1'b1}});
  assign can_retry    = (retry_cnt < RTY_W'(MAX_RETRIES));
  assign wd_expired   = tmr_zero && ((state == ST_ISSUE) || (state == ST_WAIT_DONE));
  // Entry completed: successful transfer, zero-length delay, or delay elapsed.
  assign advance = ((state == ST_CHECK) && !nack_q) ||
                   ((state == ST_DECODE) && (op_q == OP_DELAY) && (m_data == '0)) ||
                   ((state == ST_DELAY) && tmr_zero);

  i2c_cmd_sequencer_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero_c   (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (start) state_nxt = ST_FETCH;
      ST_FETCH:    state_nxt = ST_WAIT_ROM;
      ST_WAIT_ROM: state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (op_q)
          OP_END:             state_nxt = ST_FINISH;
          OP_WRITE, OP_READ:  state_nxt = ST_ISSUE;
          OP_DELAY:           state_nxt = ST_DELAY;
        endcase
      end
      ST_ISSUE: begin
        if (wd_expired)  state_nxt = ST_ERROR;
        else if (m_busy) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (wd_expired)  state_nxt = ST_ERROR;
        else if (m_done) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (nack_q) state_nxt = can_retry ? ST_ISSUE : ST_ERROR;
      end
      ST_DELAY:    ;
      ST_FINISH:   state_nxt = ST_IDLE;
      ST_ERROR:    state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    // Wrapping past the last table index aborts straight back to IDLE.
    if (advance) state_nxt = last_entry ? ST_IDLE : ST_FETCH;
  end

  always_comb begin
    cmd_addr_nxt  = cmd_addr;
    err_index_nxt = err_index;
    chip_nxt      = m_chip_addr;
    reg_nxt       = m_reg_addr;
    data_nxt      = m_data;
    op_nxt        = op_q;
    nack_nxt      = nack_q;
    retry_nxt     = retry_cnt;
    rd_data_nxt   = rd_data;
    seq_busy_nxt  = seq_busy;
    seq_error_nxt = seq_error;
    rd_valid_nxt  = 1'b0;
    seq_done_nxt  = 1'b0;
    cmd_rd_nxt    = (state_nxt == ST_FETCH);
    write_en_nxt  = (state_nxt == ST_ISSUE) && (op_q == OP_WRITE);
    read_en_nxt   = (state_nxt == ST_ISSUE) && (op_q == OP_READ);
    tmr_load      = (state_nxt == ST_ISSUE) && (state != ST_ISSUE);
    tmr_val       = WD_LOAD;
    tmr_en        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cmd_addr_nxt  = '0;
          retry_nxt     = '0;
          seq_error_nxt = 1'b0;
          seq_busy_nxt  = 1'b1;
        end
      end
      ST_WAIT_ROM: begin
        op_nxt   = op_t'(cmd_data[OP_LSB +: OP_W]);
        chip_nxt = cmd_data[CHIP_LSB +: CHIP_W];
        reg_nxt  = cmd_data[REG_LSB +: AW];
        data_nxt = cmd_data[0 +: DW];
      end
      ST_DECODE: begin
        // Load count-1 so the DELAY state lasts exactly 'data' cycles.
        if ((op_q == OP_DELAY) && (m_data != '0)) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(m_data) - TMR_W'(1);
        end
      end
      ST_ISSUE: tmr_en = 1'b1;
      ST_WAIT_DONE: begin
        tmr_en = 1'b1;
        if (m_done) nack_nxt = |m_status;
      end
      ST_CHECK: begin
        if (!nack_q && (op_q == OP_READ)) begin
          rd_data_nxt  = m_data_out;
          rd_valid_nxt = 1'b1;
        end else if (nack_q && can_retry) begin
          retry_nxt = retry_cnt + RTY_W'(1);
        end
      end
      ST_DELAY: tmr_en = 1'b1;
      ST_FINISH: begin
        seq_done_nxt = 1'b1;
        seq_busy_nxt = 1'b0;
      end
      ST_ERROR: begin
        seq_error_nxt = 1'b1;
        err_index_nxt = cmd_addr;
        seq_busy_nxt  = 1'b0;
      end
      default: ;
    endcase

    if (advance) begin
      retry_nxt = '0;
      if (last_entry) begin
        cmd_addr_nxt  = '0;
        seq_error_nxt = 1'b1;
        err_index_nxt = {CMD_AW{1'b1}};
        seq_busy_nxt  = 1'b0;
      end else begin
        cmd_addr_nxt = cmd_addr + CMD_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_rd      <= 1'b0;
      cmd_addr    <= '0;
      m_chip_addr <= '0;
      m_reg_addr  <= '0;
      m_data      <= '0;
      m_write_en  <= 1'b0;
      m_read_en   <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
      seq_error   <= 1'b0;
      err_index   <= '0;
      op_q        <= OP_END;
      nack_q      <= 1'b0;
      retry_cnt   <= '0;
    end else begin
      cmd_rd      <= cmd_rd_nxt;
      cmd_addr    <= cmd_addr_nxt;
      m_chip_addr <= chip_nxt;
      m_reg_addr  <= reg_nxt;
      m_data      <= data_nxt;
      m_write_en  <= write_en_nxt;
      m_read_en   <= read_en_nxt;
      rd_data     <= rd_data_nxt;
      rd_valid    <= rd_valid_nxt;
      seq_busy    <= seq_busy_nxt;
      seq_done    <= seq_done_nxt;
      seq_error   <= seq_error_nxt;
      err_index   <= err_index_nxt;
      op_q        <= op_nxt;
      nack_q      <= nack_nxt;
      retry_cnt   <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural ROM and i2c_master
// stand-in; watchdog shortened to 8 bits so timeouts fit in a short run.
module tb_i2c_cmd_sequencer;

  localparam int unsigned TO_WIDTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cmd_rd;
  logic [7:0]  cmd_addr;
  logic [32:0] cmd_data;
  logic [6:0]  m_chip_addr;
  logic [7:0]  m_reg_addr;
  logic [15:0] m_data;
  logic        m_write_en, m_read_en, m_write_mode;
  logic [15:0] m_data_out;
  logic [3:0]  m_status;
  logic        m_done, m_busy;
  logic [15:0] rd_data;
  logic        rd_valid, seq_busy, seq_done, seq_error;
  logic [7:0]  err_index;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.TO_WIDTH(TO_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data(m_data),
    .m_write_en(m_write_en), .m_read_en(m_read_en), .m_write_mode(m_write_mode),
    .m_data_out(m_data_out), .m_status(m_status), .m_done(m_done), .m_busy(m_busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .seq_busy(seq_busy),
    .seq_done(seq_done), .seq_error(seq_error), .err_index(err_index)
  );

  // Synchronous command ROM.
  logic [32:0] rom [256];
  always @(posedge clk) if (cmd_rd) cmd_data <= rom[cmd_addr];

  function automatic logic [32:0] mk(input logic [1:0] op, input logic [6:0] chip,
                                     input logic [7:0] r, input logic [15:0] d);
    return {op, chip, r, d};
  endfunction

  // Master stand-in, driven on the falling edge.
  logic        clr = 1'b0;
  bit          stuck = 1'b0;
  int          nack_cfg = 0, slave_lat = 2;
  logic [15:0] slave_rd = '0;
  int          sst, scnt, nack_left, issues, wr_issues;
  logic [15:0] last_data;
  logic [6:0]  last_chip;

  always @(negedge clk) begin
    if (reset || clr) begin
      sst = 0; scnt = 0; m_busy = 1'b0; m_done = 1'b0; m_status = '0; m_data_out = '0;
      issues = 0; wr_issues = 0; nack_left = nack_cfg;
    end else begin
      m_done = 1'b0;
      if (sst == 0) begin
        if ((m_write_en || m_read_en) && !stuck) begin
          m_busy = 1'b1; sst = 1; scnt = slave_lat; issues++;
          if (m_write_en) wr_issues++;
          last_data = m_data; last_chip = m_chip_addr;
        end
      end else if (scnt > 0) begin
        scnt--;
      end else begin
        m_busy = 1'b0; m_done = 1'b1; sst = 0; m_data_out = slave_rd;
        if (nack_left > 0) begin m_status = 4'b0010; nack_left--; end
        else m_status = '0;
      end
    end
  end

  // Output monitor.
  int          cyc = 0, rdv_cnt, done_cnt, fetch_n, f0, f1, we_cycles, both_cnt = 0;
  logic [15:0] rd_last;
  always @(negedge clk) begin
    cyc++;
    if (m_write_en && m_read_en) both_cnt++;
    if (clr) begin
      rdv_cnt = 0; done_cnt = 0; fetch_n = 0; f0 = 0; f1 = 0; we_cycles = 0; rd_last = '0;
    end else begin
      if (rd_valid) begin rdv_cnt++; rd_last = rd_data; end
      if (seq_done) done_cnt++;
      if (m_write_en) we_cycles++;
      if (cmd_rd) begin
        if (fetch_n == 0) f0 = cyc;
        else if (fetch_n == 1) f1 = cyc;
        fetch_n++;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int bound);
    int n;
    n = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (seq_busy && n < bound) begin tick(); n++; end
    check({tag, "_finished"}, 64'(n < bound), 64'd1);
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (3) tick();
    check("rst_a", 64'({cmd_rd, cmd_addr, m_chip_addr, m_reg_addr, m_data,
                        m_write_en, m_read_en, m_write_mode}), 64'd0);
    check("rst_b", 64'({rd_data, rd_valid, seq_busy, seq_done, seq_error, err_index}), 64'd0);
    reset = 1'b0; tick();

    // Single write then END.
    rom[0] = mk(2'd1, 7'h50, 8'h10, 16'hBEEF); rom[1] = '0;
    clear(); run_seq("wr", 200);
    check("wr_issues", 64'(wr_issues), 64'd1);
    check("wr_total", 64'(issues), 64'd1);
    check("wr_data", 64'(last_data), 64'hBEEF);
    check("wr_chip", 64'(last_chip), 64'h50);
    check("wr_done", 64'(done_cnt), 64'd1);
    check("wr_err", 64'(seq_error), 64'd0);

    // Single read then END.
    rom[0] = mk(2'd2, 7'h50, 8'h20, 16'h0000); slave_rd = 16'h1234;
    clear(); run_seq("rd", 200);
    check("rd_valid_cnt", 64'(rdv_cnt), 64'd1);
    check("rd_value", 64'(rd_last), 64'h1234);
    check("rd_done", 64'(done_cnt), 64'd1);
    check("rd_writes", 64'(wr_issues), 64'd0);
    check("rd_total", 64'(issues), 64'd1);

    // Permanent NACK: 1 + MAX_RETRIES attempts, then error at entry 0.
    rom[0] = mk(2'd1, 7'h50, 8'h10, 16'hAAAA); nack_cfg = 100;
    clear(); run_seq("nack", 400);
    check("nack_issues", 64'(issues), 64'd4);
    check("nack_err", 64'(seq_error), 64'd1);
    check("nack_idx", 64'(err_index), 64'd0);
    check("nack_done", 64'(done_cnt), 64'd0);

    // NACK once, then the table continues.
    rom[0] = mk(2'd1, 7'h50, 8'h10, 16'h1111);
    rom[1] = mk(2'd1, 7'h51, 8'h11, 16'h5555); rom[2] = '0; nack_cfg = 1;
    clear(); run_seq("retry", 400);
    check("retry_issues", 64'(issues), 64'd3);
    check("retry_done", 64'(done_cnt), 64'd1);
    check("retry_err", 64'(seq_error), 64'd0);
    check("retry_data", 64'(last_data), 64'h5555);
    check("retry_addr", 64'(cmd_addr), 64'd2);
    nack_cfg = 0;

    // DELAY 100: next fetch is FETCH+WAIT_ROM+DECODE+100 cycles later.
    rom[0] = mk(2'd3, 7'h00, 8'h00, 16'd100);
    rom[1] = mk(2'd1, 7'h50, 8'h10, 16'h0F0F); rom[2] = '0;
    clear(); run_seq("dly100", 400);
    check("dly100_gap", 64'(f1 - f0), 64'd103);
    check("dly100_done", 64'(done_cnt), 64'd1);
    rom[0] = mk(2'd3, 7'h00, 8'h00, 16'd0);
    clear(); run_seq("dly0", 400);
    check("dly0_gap", 64'(f1 - f0), 64'd3);
    check("dly0_done", 64'(done_cnt), 64'd1);

    // Master never goes busy: watchdog aborts after 2^TO_WIDTH cycles in ISSUE.
    rom[0] = mk(2'd1, 7'h50, 8'h10, 16'hBEEF); rom[1] = '0; stuck = 1'b1;
    clear(); run_seq("wdog", 600);
    check("wdog_en_cycles", 64'(we_cycles), 64'd256);
    check("wdog_err", 64'(seq_error), 64'd1);
    check("wdog_idx", 64'(err_index), 64'd0);
    check("wdog_en_low", 64'({m_write_en, m_read_en}), 64'd0);
    check("wdog_done", 64'(done_cnt), 64'd0);
    stuck = 1'b0;

    // Table of DELAY 0 only: must wrap into an error, not loop.
    for (int i = 0; i < 256; i++) rom[i] = mk(2'd3, 7'h00, 8'h00, 16'd0);
    clear(); run_seq("wrap", 2000);
    check("wrap_err", 64'(seq_error), 64'd1);
    check("wrap_idx", 64'(err_index), 64'hFF);
    check("wrap_addr", 64'(cmd_addr), 64'd0);
    check("wrap_done", 64'(done_cnt), 64'd0);

    // Reset while waiting for a slow master's done.
    rom[0] = mk(2'd1, 7'h50, 8'h10, 16'hBEEF); rom[1] = '0; slave_lat = 40;
    clear();
    start = 1'b1; tick(); start = 1'b0;
    begin
      int n;
      n = 0;
      while (!(m_busy && !m_write_en) && n < 50) begin tick(); n++; end
      check("mid_reached", 64'(n < 50), 64'd1);
    end
    tick(); tick();
    reset = 1'b1; tick();
    check("mid_rst_a", 64'({cmd_rd, cmd_addr, m_chip_addr, m_reg_addr, m_data,
                            m_write_en, m_read_en, m_write_mode}), 64'd0);
    check("mid_rst_b", 64'({rd_data, rd_valid, seq_busy, seq_done, seq_error, err_index}), 64'd0);
    reset = 1'b0; tick();

    check("both_en_never", 64'(both_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
